// File: rtl/i8088_bus_pkg.sv
// Shared types and constants for the 8088 minimum-mode bus cycle controller.
package i8088_bus_pkg;

  // One state per bus clock of an 8088 bus cycle, plus idle and hold.
  typedef enum logic [2:0] {TI, T1, T2, T3, TW, T4, TH} bus_state_t;

  // Request captured at acceptance and held for the whole bus cycle.
  typedef struct packed {
    logic [19:0] addr;
    logic [7:0]  wdata;
    logic        write;
    logic        io;
  } bus_req_t;

  // Inactive level of the active-low strobes RD, WR and DEN.
  localparam logic STROBE_IDLE = 1'b1;

  // Read data returned when a cycle is aborted by the wait-state timeout.
  localparam logic [7:0] ABORT_RDATA = 8'hFF;

  // Wait counter width when no timeout is built in (covers MIN_WAIT up to 15).
  localparam int WC_W_DEFAULT = 4;

endpackage

// File: rtl/i8088_wait_counter.sv
// Wait-state counter: cleared in T2, bumped on every entry into TW, saturating.
// Reports whether the forced minimum wait is satisfied and whether the
// timeout limit has been reached (the latter only when TIMEOUT_EN is set).
module i8088_wait_counter #(
  parameter int WIDTH      = 4,
  parameter int MIN_WAIT   = 0,
  parameter int LIMIT      = 16,
  parameter bit TIMEOUT_EN = 1'b0
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clear,
  input  logic inc,
  output logic min_met,
  output logic timeout
);

  logic [WIDTH-1:0] wc;

  // Count TW states of the current cycle; saturate so a long wait cannot wrap.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wc <= '0;
    end else if (clear) begin
      wc <= '0;
    end else if (inc && (wc != '1)) begin
      wc <= wc + 1'b1;
    end
  end

  assign min_met = int'(wc) >= MIN_WAIT;
  assign timeout = TIMEOUT_EN && (int'(wc) >= LIMIT);

endmodule

// File: rtl/i8088_bus_cycle_ctrl.sv
// 8088 minimum-mode bus cycle sequencer: turns valid/ready requests into
// T1/T2/T3/Tw/T4 pin sequences and handles HOLD/HLDA hand-off.
// Optional feature macro: BUS_TIMEOUT_EN (abort a cycle after TIMEOUT_CYCLES Tw).
module i8088_bus_cycle_ctrl
  import i8088_bus_pkg::*;
#(
  parameter int MIN_WAIT       = 0,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_io,
  input  logic [19:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  input  logic        READY,
  input  logic        HOLD,
  output logic        HLDA,
  output logic [7:0]  AD_out,
  output logic        AD_oe,
  input  logic [7:0]  AD_in,
  output logic [11:0] A,
  output logic        IOM,
  output logic        WR,
  output logic        RD,
  output logic        ALE,
  output logic        DTR,
  output logic        DEN,
  output logic        bus_float
);

`ifdef BUS_TIMEOUT_EN
  localparam int WC_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam bit TO_EN = 1'b1;
`else
  localparam int WC_W  = WC_W_DEFAULT;
  localparam bit TO_EN = 1'b0;
`endif

  bus_state_t state, state_nx;
  bus_req_t   req_q;
  logic       accept, waiting, finishing, abort;
  logic       min_met, timeout;

  assign req_ready = !RESET && !HOLD && ((state == TI) || (state == T4));
  assign accept    = req_valid && req_ready;
  assign waiting   = (state == T3) || (state == TW);
  assign finishing = waiting && (state_nx == T4);

  i8088_wait_counter #(
    .WIDTH     (WC_W),
    .MIN_WAIT  (MIN_WAIT),
    .LIMIT     (TIMEOUT_CYCLES),
    .TIMEOUT_EN(TO_EN)
  ) u_wait (
    .CLK    (CLK),
    .RESET  (RESET),
    .clear  (state == T2),
    .inc    (waiting && (state_nx == TW)),
    .min_met(min_met),
    .timeout(timeout)
  );

  // State register; reset forces idle immediately, even mid-cycle.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= TI;
    else       state <= state_nx;
  end

  // Next state: HOLD beats a new request at TI/T4; READY only matters in T3/TW.
  always_comb begin
    state_nx = state;
    abort    = 1'b0;
    case (state)
      TI, T4: begin
        if (HOLD)           state_nx = TH;
        else if (req_valid) state_nx = T1;
        else                state_nx = TI;
      end
      T1: state_nx = T2;
      T2: state_nx = T3;
      T3, TW: begin
        if (READY && min_met) begin
          state_nx = T4;
        end else if ((state == TW) && timeout) begin
          state_nx = T4;
          abort    = 1'b1;
        end else begin
          state_nx = TW;
        end
      end
      TH: state_nx = HOLD ? TH : TI;
      default: state_nx = TI;
    endcase
  end

  // Latch the request on acceptance; it drives A/IOM/DTR until the next one.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      req_q <= '0;
    end else if (accept) begin
      req_q.addr  <= req_addr;
      req_q.wdata <= req_wdata;
      req_q.write <= req_write;
      req_q.io    <= req_io;
    end
  end

  // Capture read data from the pins as the cycle leaves T3/TW.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rsp_rdata <= '0;
    end else if (finishing) begin
      if (abort)             rsp_rdata <= ABORT_RDATA;
      else if (!req_q.write) rsp_rdata <= AD_in;
    end
  end

`ifdef BUS_TIMEOUT_EN
  logic err_q;

  // Remember whether the cycle now in T4 was cut short by the timeout.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)          err_q <= 1'b0;
    else if (finishing) err_q <= abort;
  end

  assign rsp_err = (state == T4) && err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // Pin decode from the current state and the latched request.
  always_comb begin
    ALE    = 1'b0;
    RD     = STROBE_IDLE;
    WR     = STROBE_IDLE;
    DEN    = STROBE_IDLE;
    AD_oe  = 1'b0;
    AD_out = '0;
    case (state)
      T1: begin
        ALE    = 1'b1;
        AD_oe  = 1'b1;
        AD_out = req_q.addr[7:0];
      end
      T2, T3, TW: begin
        DEN = 1'b0;
        if (req_q.write) begin
          WR     = 1'b0;
          AD_oe  = 1'b1;
          AD_out = req_q.wdata;
        end else begin
          RD = 1'b0;
        end
      end
      T4: begin
        if (req_q.write) begin
          AD_oe  = 1'b1;
          AD_out = req_q.wdata;
        end
      end
      default: ;
    endcase
  end

  assign A         = req_q.addr[19:8];
  assign IOM       = req_q.io;
  assign DTR       = req_q.write;
  assign HLDA      = (state == TH);
  assign bus_float = (state == TH);
  assign rsp_valid = (state == T4);

endmodule

// File: tb/tb_i8088_bus_cycle_ctrl.sv
// Directed testbench for i8088_bus_cycle_ctrl. The pin bundle compared at each
// step is {ALE,RD,WR,DEN,AD_oe,IOM,DTR,HLDA,bus_float,rsp_valid,rsp_err,req_ready}.
module tb_i8088_bus_cycle_ctrl;

  logic        CLK, RESET;
  logic        req_valid, req_ready, req_write, req_io;
  logic [19:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid, rsp_err;
  logic [7:0]  rsp_rdata;
  logic        READY, HOLD, HLDA;
  logic [7:0]  AD_out, AD_in;
  logic        AD_oe;
  logic [11:0] A;
  logic        IOM, WR, RD, ALE, DTR, DEN, bus_float;
  logic [11:0] pins;

  int n_asserts = 0;
  int n_fails   = 0;

  i8088_bus_cycle_ctrl #(.MIN_WAIT(0), .TIMEOUT_CYCLES(4)) dut (
    .CLK(CLK), .RESET(RESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_io(req_io), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .READY(READY), .HOLD(HOLD), .HLDA(HLDA),
    .AD_out(AD_out), .AD_oe(AD_oe), .AD_in(AD_in), .A(A),
    .IOM(IOM), .WR(WR), .RD(RD), .ALE(ALE), .DTR(DTR), .DEN(DEN),
    .bus_float(bus_float)
  );

  assign pins = {ALE, RD, WR, DEN, AD_oe, IOM, DTR, HLDA, bus_float,
                 rsp_valid, rsp_err, req_ready};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic w, input logic io,
                               input logic [19:0] addr, input logic [7:0] wd);
    req_valid = v;
    req_write = w;
    req_io    = io;
    req_addr  = addr;
    req_wdata = wd;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    RESET = 1'b1;
    READY = 1'b1;
    HOLD  = 1'b0;
    AD_in = 8'h00;
    applyStimulus(1'b0, 1'b0, 1'b0, 20'h0, 8'h0);

    // Reset state
    #3;
    checkOutput("reset_pins",  32'(pins),      32'(12'b0111_0000_0000));
    checkOutput("reset_A",     32'(A),         32'h000);
    checkOutput("reset_AD",    32'(AD_out),    32'h00);
    checkOutput("reset_rdata", 32'(rsp_rdata), 32'h00);
    tick();
    tick();
    checkOutput("reset_hold_pins", 32'(pins), 32'(12'b0111_0000_0000));
    RESET = 1'b0;
    #1;
    checkOutput("ready_after_reset", 32'(pins), 32'(12'b0111_0000_0001));

    // Memory read, no waits
    $display("[TB] memory read 12345");
    applyStimulus(1'b1, 1'b0, 1'b0, 20'h12345, 8'h00);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 20'h0, 8'h0);
    checkOutput("rd_t1_pins", 32'(pins),   32'(12'b1111_1000_0000));
    checkOutput("rd_t1_A",    32'(A),      32'h123);
    checkOutput("rd_t1_AD",   32'(AD_out), 32'h45);
    tick();
    AD_in = 8'h5A;
    checkOutput("rd_t2_pins", 32'(pins), 32'(12'b0010_0000_0000));
    tick();
    checkOutput("rd_t3_pins", 32'(pins), 32'(12'b0010_0000_0000));
    tick();
    AD_in = 8'h00;
    checkOutput("rd_t4_pins",  32'(pins),      32'(12'b0111_0000_0101));
    checkOutput("rd_t4_rdata", 32'(rsp_rdata), 32'h5A);
    checkOutput("rd_t4_A",     32'(A),         32'h123);
    tick();
    checkOutput("rd_ti_pins",  32'(pins),      32'(12'b0111_0000_0001));
    checkOutput("rd_ti_rdata", 32'(rsp_rdata), 32'h5A);

    // IO write with three wait states
    $display("[TB] io write 00080 <= C3");
    READY = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b1, 20'h00080, 8'hC3);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 20'h0, 8'h0);
    checkOutput("wr_t1_pins", 32'(pins),   32'(12'b1111_1110_0000));
    checkOutput("wr_t1_A",    32'(A),      32'h000);
    checkOutput("wr_t1_AD",   32'(AD_out), 32'h80);
    tick();
    checkOutput("wr_t2_pins", 32'(pins),   32'(12'b0100_1110_0000));
    checkOutput("wr_t2_AD",   32'(AD_out), 32'hC3);
    tick();
    checkOutput("wr_t3_pins", 32'(pins), 32'(12'b0100_1110_0000));
    tick();
    checkOutput("wr_tw1_pins", 32'(pins), 32'(12'b0100_1110_0000));
    tick();
    checkOutput("wr_tw2_pins", 32'(pins), 32'(12'b0100_1110_0000));
    tick();
    checkOutput("wr_tw3_pins", 32'(pins), 32'(12'b0100_1110_0000));
    READY = 1'b1;
    tick();
    checkOutput("wr_t4_pins",  32'(pins),      32'(12'b0111_1110_0101));
    checkOutput("wr_t4_AD",    32'(AD_out),    32'hC3);
    checkOutput("wr_t4_rdata", 32'(rsp_rdata), 32'h5A);
    tick();
    checkOutput("wr_ti_pins", 32'(pins), 32'(12'b0111_0110_0001));

    // Back-to-back reads with req_valid held
    $display("[TB] back-to-back reads");
    applyStimulus(1'b1, 1'b0, 1'b0, 20'hABCDE, 8'h00);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 20'h54321, 8'h00);
    checkOutput("b2b_a_t1_A",  32'(A),      32'hABC);
    checkOutput("b2b_a_t1_AD", 32'(AD_out), 32'hDE);
    tick();
    AD_in = 8'h77;
    tick();
    tick();
    checkOutput("b2b_a_t4_pins",  32'(pins),      32'(12'b0111_0000_0101));
    checkOutput("b2b_a_t4_rdata", 32'(rsp_rdata), 32'h77);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 20'h0, 8'h0);
    checkOutput("b2b_b_t1_pins", 32'(pins),   32'(12'b1111_1000_0000));
    checkOutput("b2b_b_t1_A",    32'(A),      32'h543);
    checkOutput("b2b_b_t1_AD",   32'(AD_out), 32'h21);
    tick();
    AD_in = 8'h88;
    tick();
    tick();
    checkOutput("b2b_b_t4_rdata", 32'(rsp_rdata), 32'h88);
    tick();
    checkOutput("b2b_ti_pins", 32'(pins), 32'(12'b0111_0000_0001));

    // HOLD raised mid-cycle: cycle completes, then hold, then pending request
    $display("[TB] hold during T2");
    applyStimulus(1'b1, 1'b0, 1'b0, 20'h0F0F0, 8'h00);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 20'h0, 8'h0);
    tick();
    HOLD = 1'b1;
    tick();
    checkOutput("hold_t3_pins", 32'(pins), 32'(12'b0010_0000_0000));
    tick();
    checkOutput("hold_t4_pins", 32'(pins), 32'(12'b0111_0000_0100));
    applyStimulus(1'b1, 1'b0, 1'b0, 20'h22222, 8'h00);
    tick();
    checkOutput("hold_th1_pins", 32'(pins), 32'(12'b0111_0001_1000));
    tick();
    checkOutput("hold_th2_pins", 32'(pins), 32'(12'b0111_0001_1000));
    HOLD = 1'b0;
    #1;
    checkOutput("hold_drop_pins", 32'(pins), 32'(12'b0111_0001_1000));
    tick();
    checkOutput("hold_exit_pins", 32'(pins), 32'(12'b0111_0000_0001));
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 20'h0, 8'h0);
    checkOutput("hold_t1_pins", 32'(pins), 32'(12'b1111_1000_0000));
    checkOutput("hold_t1_A",    32'(A),    32'h222);

    // Reset pulse while waiting in TW
    $display("[TB] reset during TW");
    tick();
    READY = 1'b0;
    tick();
    tick();
    checkOutput("rst_tw_pins", 32'(pins), 32'(12'b0010_0000_0000));
    #2;
    RESET = 1'b1;
    #1;
    checkOutput("rst_async_pins",  32'(pins),      32'(12'b0111_0000_0000));
    checkOutput("rst_async_A",     32'(A),         32'h000);
    checkOutput("rst_async_rdata", 32'(rsp_rdata), 32'h00);
    tick();
    checkOutput("rst_held_pins", 32'(pins), 32'(12'b0111_0000_0000));
    RESET = 1'b0;
    READY = 1'b1;
    #1;
    checkOutput("rst_release_pins", 32'(pins), 32'(12'b0111_0000_0001));
    tick();
    checkOutput("rst_idle_pins", 32'(pins), 32'(12'b0111_0000_0001));

`ifdef BUS_TIMEOUT_EN
    // READY stuck low: four TW states, then an aborted T4
    $display("[TB] timeout abort");
    READY = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 20'h00F00, 8'h00);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 20'h0, 8'h0);
    tick();
    tick();
    tick();
    checkOutput("to_tw1_pins", 32'(pins), 32'(12'b0010_0000_0000));
    tick();
    tick();
    tick();
    checkOutput("to_tw4_pins", 32'(pins), 32'(12'b0010_0000_0000));
    tick();
    checkOutput("to_t4_pins",  32'(pins),      32'(12'b0111_0000_0111));
    checkOutput("to_t4_rdata", 32'(rsp_rdata), 32'hFF);
    READY = 1'b1;
    tick();
    checkOutput("to_ti_pins", 32'(pins), 32'(12'b0111_0000_0001));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule

// File: doc/i8088_bus_cycle_ctrl.md
Name: i8088_bus_cycle_ctrl

Overview:
- Sequencer that turns a valid/ready request stream (mem/IO, read/write) into 8088 minimum-mode bus cycles: T1, T2, T3, optional Tw, T4.
- Drives the processor-side pins of the Intel8088Pins bundle: ALE, RD, WR, IOM, DTR, DEN, A, AD.
- Honours READY wait states and the HOLD/HLDA bus hand-off.
- Sits between the CPU execution model and the bus interface.

Parameters:
- MIN_WAIT, 0: Tw states forced on every cycle regardless of READY (0..15).
- TIMEOUT_CYCLES, 16: maximum Tw states before abort (only used with BUS_TIMEOUT_EN).

Ports:
- CLK, input, 1: bus clock; all state changes on the rising edge.
- RESET, input, 1: asynchronous, active-high reset.
- req_valid, input, 1: request present.
- req_ready, output, 1: controller accepts the request this cycle.
- req_write, input, 1: 1 = write, 0 = read.
- req_io, input, 1: 1 = IO space, 0 = memory.
- req_addr, input, 20: cycle address.
- req_wdata, input, 8: write data.
- rsp_valid, output, 1: one-cycle pulse at cycle completion.
- rsp_rdata, output, 8: read data, valid with rsp_valid.
- rsp_err, output, 1: cycle aborted by timeout, valid with rsp_valid.
- READY, input, 1: wait-state control.
- HOLD, input, 1: external bus request.
- HLDA, output, 1: hold acknowledge.
- AD_out, output, 8: multiplexed address/data out.
- AD_oe, output, 1: AD driver enable.
- AD_in, input, 8: AD pin sample.
- A, output, 12: address [19:8].
- IOM, output, 1: 1 = IO cycle.
- WR, output, 1: active-low write strobe.
- RD, output, 1: active-low read strobe.
- ALE, output, 1: address latch enable.
- DTR, output, 1: 1 = transmit.
- DEN, output, 1: active-low data enable.
- bus_float, output, 1: 1 = pin drivers must tristate (hold).

Behaviour:
- Reset values (asynchronous, immediate, including mid-cycle):
  - FSM = TI.
  - RD = WR = DEN = 1.
  - ALE = AD_oe = HLDA = bus_float = rsp_valid = rsp_err = 0.
  - IOM = DTR = 0; A = AD_out = 0; rsp_rdata = 0.
  - req_ready = 0 while RESET is high; req_ready = 1 in the first TI after release.
- States: TI, T1, T2, T3, TW, T4, TH. Every state lasts one CLK.
- Acceptance:
  - req_ready = 1 in TI and T4 when HOLD = 0.
  - On req_valid & req_ready, addr, write, io and wdata are registered; next state = T1.
  - Back-to-back cycles allowed: T4 -> T1.
- T1: ALE = 1; AD_oe = 1 with AD_out = addr[7:0]; A = addr[19:8]; IOM and DTR set from the request and held through T4.
- T2:
  - ALE = 0; DEN = 0.
  - Read: AD_oe = 0, RD = 0.
  - Write: AD_oe = 1, AD_out = wdata, WR = 0.
- T3 / TW:
  - Strobes held.
  - Wait counter wc reset to 0 in T2 and incremented in each TW.
  - Leave to T4 when READY = 1 and wc >= MIN_WAIT; otherwise go to TW.
  - Read data: on leaving to T4, AD_in is captured into rsp_rdata.
- T4:
  - RD = WR = DEN = 1; AD_oe = 0 for reads; write data held through T4.
  - rsp_valid = 1 for this cycle only.
  - A, IOM and DTR keep their values.
- Hold entry:
  - HOLD is sampled only in TI and in T4. It is never granted inside T1..TW.
  - If HOLD = 1 there, next state = TH, taking priority over a valid request; no request is accepted.
- TH: HLDA = 1, bus_float = 1, AD_oe = 0, req_ready = 0.
- Hold exit: the first cycle HOLD = 0 gives HLDA = 0 next edge, state = TI, bus_float = 0.
- READY is ignored outside T3/TW.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Defined:
  - In TW, if wc reaches TIMEOUT_CYCLES with READY still 0, force T4.
  - rsp_err = 1 with rsp_valid; rsp_rdata = 8'hFF.
  - wc width = clog2(TIMEOUT_CYCLES+1).
- Undefined:
  - TW persists indefinitely; rsp_err is tied to 0.

Decomposition:
- Package i8088_bus_pkg:
  - Enum bus_state_t {TI, T1, T2, T3, TW, T4, TH}.
  - Struct bus_req_t {addr, wdata, write, io}.
  - Constants for active-low inactive levels.
- One sub-module, i8088_wait_counter: clear/increment, min_met, timeout flags.

Test Plan:
- Memory read: addr 20'h12345, READY = 1 -> ALE only in T1; AD_out = 8'h45, A = 12'h123; RD low T2–T3; AD_in = 8'h5A captured; rsp_valid in T4 with rsp_rdata = 8'h5A; 4 clocks total.
- IO write: addr 20'h00080, data 8'hC3, READY = 0 for 3 cycles -> IOM = 1, DTR = 1, WR low T2..last TW; 3 TW states; rsp_valid 7 clocks after T1 start.
- Back-to-back: two reads presented with req_valid held -> second T1 immediately follows first T4; no TI gap.
- HOLD asserted during T2 -> cycle completes normally; TH entered after T4; HLDA = 1, bus_float = 1; HOLD drops -> HLDA = 0 next edge, pending request starts T1 one cycle later.
- RESET pulsed during TW -> all outputs return to reset values asynchronously; no rsp_valid issued.
- BUS_TIMEOUT_EN, TIMEOUT_CYCLES = 4, READY stuck 0 -> exactly 4 TW, then T4 with rsp_err = 1, rsp_rdata = 8'hFF.
